// File: rtl/cpu_pkg.sv
// =============================================================================
// Module      : cpu_pkg
// Description : Opcode constants, extension-mode enum and opcode decode for
//               the immediate/operand extension stage.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package cpu_pkg;

   localparam logic [5:0] OP_BRA  = 6'h16;
   localparam logic [5:0] OP_JUMP = 6'h15;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LUI  = 6'h0F;

   typedef enum logic [2:0] {
      MODE_SEXT = 3'd0,
      MODE_ZEXT = 3'd1,
      MODE_BRA  = 3'd2,
      MODE_JMP  = 3'd3,
      MODE_LUI  = 3'd4
   } ext_mode_t;

   function automatic ext_mode_t opcode_to_mode(input logic [5:0] opcode);
      case (opcode)
         OP_BRA:         return MODE_BRA;
         OP_JUMP:        return MODE_JMP;
         OP_ANDI, OP_ORI: return MODE_ZEXT;
         OP_LUI:         return MODE_LUI;
         default:        return MODE_SEXT;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_extend_stage_if.sv
// =============================================================================
// Module      : imm_extend_stage_if
// Description : Valid/ready bundle between decode and the extension stage
//               (master drives beats in and accepts results).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface imm_extend_stage_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int JMP_W  = 26,
   parameter int RS_W   = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        opcode;
   logic [IMM_W-1:0]  imm;
   logic [JMP_W-1:0]  jmp;
   logic [RS_W-1:0]   rs;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] imm_out;
   logic [DATA_W-1:0] rs_out;
   logic [2:0]        mode_out;

   modport master (
      output in_valid, opcode, imm, jmp, rs, out_ready,
      input  in_ready, out_valid, imm_out, rs_out, mode_out
   );

   modport slave (
      input  in_valid, opcode, imm, jmp, rs, out_ready,
      output in_ready, out_valid, imm_out, rs_out, mode_out
   );
endinterface

`default_nettype wire

// File: rtl/imm_ext_comb.sv
// =============================================================================
// Module      : imm_ext_comb
// Description : Combinational opcode-to-mode decode plus sign/zero/upper
//               extension of immediate, jump target and rs fields.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module imm_ext_comb
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int IMM_W     = 16,
   parameter int JMP_W     = 26,
   parameter int RS_W      = 5,
   parameter int BR_SHIFT  = 0,
   parameter int JMP_SHIFT = 0
) (
   input  wire logic [5:0]        opcode,
   input  wire logic [IMM_W-1:0]  imm,
   input  wire logic [JMP_W-1:0]  jmp,
   input  wire logic [RS_W-1:0]   rs,
   output ext_mode_t              mode,
   output logic      [DATA_W-1:0] imm_ext,
   output logic      [DATA_W-1:0] rs_ext
);
   localparam int c_lui_shift = DATA_W - IMM_W;

   logic [DATA_W-1:0] w_imm_sext;
   logic [DATA_W-1:0] w_imm_zext;
   logic [DATA_W-1:0] w_jmp_sext;
   logic [DATA_W-1:0] w_rs_sext;
   logic [DATA_W-1:0] w_rs_zext;

   // Size casts on signed operands replicate the sign bit
   assign w_imm_sext = DATA_W'($signed(imm));
   assign w_imm_zext = DATA_W'(imm);
   assign w_jmp_sext = DATA_W'($signed(jmp));
   assign w_rs_sext  = DATA_W'($signed(rs));
   assign w_rs_zext  = DATA_W'(rs);

   always_comb begin
      mode    = opcode_to_mode(opcode);
      imm_ext = w_imm_sext;
      rs_ext  = w_rs_zext;
      case (mode)
         MODE_BRA: begin
            imm_ext = w_imm_sext << BR_SHIFT;
            rs_ext  = w_rs_sext;
         end
         MODE_JMP:  imm_ext = w_jmp_sext << JMP_SHIFT;
         MODE_ZEXT: imm_ext = w_imm_zext;
         MODE_LUI:  imm_ext = w_imm_zext << c_lui_shift;
         default:   imm_ext = w_imm_sext;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/imm_extend_stage.sv
// =============================================================================
// Module      : imm_extend_stage
// Description : Registered extension stage with valid/ready handshake and
//               flush. Define IMM_EXT_SKID_EN for a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module imm_extend_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int IMM_W     = 16,
   parameter int JMP_W     = 26,
   parameter int RS_W      = 5,
   parameter int BR_SHIFT  = 0,
   parameter int JMP_SHIFT = 0
) (
   input wire logic clk,
   input wire logic reset,
   input wire logic flush,
   imm_extend_stage_if.slave bus
);
   ext_mode_t         w_mode;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_rs_ext;
   logic              w_in_ready;
   logic              w_xfer_in;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_rs;
   ext_mode_t         r_mode;

   imm_ext_comb #(
      .DATA_W(DATA_W), .IMM_W(IMM_W), .JMP_W(JMP_W), .RS_W(RS_W),
      .BR_SHIFT(BR_SHIFT), .JMP_SHIFT(JMP_SHIFT)
   ) u_ext (
      .opcode (bus.opcode),
      .imm    (bus.imm),
      .jmp    (bus.jmp),
      .rs     (bus.rs),
      .mode   (w_mode),
      .imm_ext(w_imm_ext),
      .rs_ext (w_rs_ext)
   );

   assign w_xfer_in     = bus.in_valid && w_in_ready && !flush;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.imm_out   = r_imm;
   assign bus.rs_out    = r_rs;
   assign bus.mode_out  = r_mode;

`ifdef IMM_EXT_SKID_EN
   logic              r_in_ready;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_imm;
   logic [DATA_W-1:0] r_skid_rs;
   ext_mode_t         r_skid_mode;

   // Registered ready keeps out_ready off the upstream timing path
   assign w_in_ready = r_in_ready && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_imm        <= '0;
         r_rs         <= '0;
         r_mode       <= MODE_SEXT;
         r_skid_imm   <= '0;
         r_skid_rs    <= '0;
         r_skid_mode  <= MODE_SEXT;
      end else if (flush) begin
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_xfer_in) begin
         if (!r_out_valid || bus.out_ready) begin
            r_out_valid <= 1'b1;
            r_imm       <= w_imm_ext;
            r_rs        <= w_rs_ext;
            r_mode      <= w_mode;
         end else begin
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
            r_skid_imm   <= w_imm_ext;
            r_skid_rs    <= w_rs_ext;
            r_skid_mode  <= w_mode;
         end
      end else if (r_out_valid && bus.out_ready) begin
         if (r_skid_valid) begin
            r_imm        <= r_skid_imm;
            r_rs         <= r_skid_rs;
            r_mode       <= r_skid_mode;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end
`else
   assign w_in_ready = !reset && (!r_out_valid || bus.out_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_imm       <= '0;
         r_rs        <= '0;
         r_mode      <= MODE_SEXT;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_xfer_in) begin
         r_out_valid <= 1'b1;
         r_imm       <= w_imm_ext;
         r_rs        <= w_rs_ext;
         r_mode      <= w_mode;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire
